// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- serial-to-byte receiver with a valid/ready output holding register.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames (one even
// parity bit after the data bits); otherwise frames are 8N1.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz
//   BAUD      line bit rate
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rx        asynchronous serial line, idle high
//   data      received byte
//   valid     data holds an unconsumed byte
//   ready     consumer accepts data when valid && ready
//   frame_err one-cycle pulse: bad stop bit (or parity mismatch)
//   overrun   one-cycle pulse: a completed byte was dropped, holding register full
module uart_rx_byte #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic             rx_meta, rx_sync, rx_d;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic             s7, s8;
    logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
    logic             par_err;
`endif

    logic tick, maj, at_mid, at_end, start_edge;
    logic byte_done, frame_bad;

    assign tick       = (state != IDLE) && (div_cnt == DIV_LAST);
    // 2-of-3 vote over ticks 7, 8 and the live sample at tick 9
    assign maj        = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
    assign at_mid     = tick && (tick_cnt == 4'd9);
    assign at_end     = tick && (tick_cnt == 4'd15);
    assign start_edge = (state == IDLE) && rx_d && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) state_next = START;
            end
            START: begin
                if (at_mid && maj)  state_next = IDLE;
                else if (at_end)    state_next = DATA;
            end
            DATA: begin
                if (at_end && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_end) state_next = STOP;
            end
`endif
            STOP: begin
                // Leave at mid-bit so a start edge right after the stop bit is seen
                if (at_mid) begin
                    state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (maj && !par_err) byte_done = 1'b1;
                    else                 frame_bad = 1'b1;
`else
                    if (maj) byte_done = 1'b1;
                    else     frame_bad = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_d     <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            s7       <= 1'b0;
            s8       <= 1'b0;
            shift    <= '0;
`ifdef UART_RX_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_d    <= rx_sync;

            if (start_edge) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                par_err  <= 1'b0;
`endif
            end else if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) tick_cnt <= tick_cnt + 1'b1;
                if ((state == DATA) && at_end) bit_cnt <= bit_cnt + 1'b1;
            end

            if (tick && (tick_cnt == 4'd7)) s7 <= rx_sync;
            if (tick && (tick_cnt == 4'd8)) s8 <= rx_sync;

            if ((state == DATA) && at_mid) shift <= {maj, shift[7:1]};
`ifdef UART_RX_PARITY_EN
            if ((state == PARITY) && at_mid) par_err <= (maj != ^shift);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte -- directed bench for uart_rx_byte at DIV=1 (16 clk per bit).
// Define UART_RX_PARITY_EN for both files to exercise the parity frames.
module tb_uart_rx_byte;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // event monitor: cycle counts and rising-edge counts of each output
    int unsigned v_cyc = 0, v_rise = 0, fe_cyc = 0, fe_rise = 0, ov_cyc = 0, ov_rise = 0;
    logic        v_q = 1'b0, fe_q = 1'b0, ov_q = 1'b0;
    logic [7:0]  last_data = 8'h00;

    // baselines taken by the stimulus process
    int unsigned b_v_cyc, b_v_rise, b_fe_cyc, b_fe_rise, b_ov_cyc, b_ov_rise;

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_byte #(
        .CLK_HZ(1_600_000),
        .BAUD  (100_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            v_cyc     <= v_cyc + 1;
            last_data <= data;
        end
        if (valid && !v_q)          v_rise  <= v_rise + 1;
        if (frame_err)              fe_cyc  <= fe_cyc + 1;
        if (frame_err && !fe_q)     fe_rise <= fe_rise + 1;
        if (overrun)                ov_cyc  <= ov_cyc + 1;
        if (overrun && !ov_q)       ov_rise <= ov_rise + 1;
        v_q  <= valid;
        fe_q <= frame_err;
        ov_q <= overrun;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b ^ par_flip);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic snap();
        b_v_cyc   = v_cyc;
        b_v_rise  = v_rise;
        b_fe_cyc  = fe_cyc;
        b_fe_rise = fe_rise;
        b_ov_cyc  = ov_cyc;
        b_ov_rise = ov_rise;
    endtask

    initial begin
        // reset state
        idle(3);
        check("rst_data",  32'(data),      32'h00);
        check("rst_valid", 32'(valid),     32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovr",   32'(overrun),   32'h0);
        rst_n = 1'b1;
        idle(5);

        // 0xA5 with ready high: single-cycle valid
        ready = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1);
        idle(4);
        check("a5_valid_rise", v_rise - b_v_rise, 1);
        check("a5_valid_cyc",  v_cyc - b_v_cyc,   1);
        check("a5_data",       32'(last_data),    32'hA5);
        check("a5_ferr",       fe_cyc - b_fe_cyc, 0);
        check("a5_ovr",        ov_cyc - b_ov_cyc, 0);

        // 0x3C then 0xC3 back-to-back with ready low: second byte dropped
        ready = 1'b0;
        snap();
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(4);
        check("b2b_valid_held", 32'(valid),         32'h1);
        check("b2b_data",       32'(data),          32'h3C);
        check("b2b_valid_rise", v_rise - b_v_rise,  1);
        check("b2b_ovr_rise",   ov_rise - b_ov_rise, 1);
        check("b2b_ovr_cyc",    ov_cyc - b_ov_cyc,  1);
        check("b2b_ferr",       fe_cyc - b_fe_cyc,  0);
        ready = 1'b1;
        idle(1);
        check("b2b_valid_clr",  32'(valid),         32'h0);
        check("b2b_data_kept",  32'(data),          32'h3C);
        idle(3);

        // 0x55 with stop bit low: frame error, byte discarded
        snap();
        send_byte(8'h55, 1'b0);
        idle(4);
        check("fe_rise",   fe_rise - b_fe_rise, 1);
        check("fe_cyc",    fe_cyc - b_fe_cyc,   1);
        check("fe_valid",  v_cyc - b_v_cyc,     0);
        check("fe_data",   32'(data),           32'h3C);

        // 4-clk glitch: false start, then a good 0x81
        snap();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(24);
        check("fs_valid", v_cyc - b_v_cyc,   0);
        check("fs_ferr",  fe_cyc - b_fe_cyc, 0);
        snap();
        send_byte(8'h81, 1'b1);
        idle(4);
        check("fs81_valid_rise", v_rise - b_v_rise, 1);
        check("fs81_data",       32'(last_data),    32'h81);
        check("fs81_ferr",       fe_cyc - b_fe_cyc, 0);

        // reset during bit 4 of 0xFF, then 0x12
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        idle(8);
        rst_n = 1'b0;
        idle(2);
        check("mrst_data",  32'(data),      32'h00);
        check("mrst_valid", 32'(valid),     32'h0);
        check("mrst_ferr",  32'(frame_err), 32'h0);
        check("mrst_ovr",   32'(overrun),   32'h0);
        rst_n = 1'b1;
        idle(8 + 16 * 3 + 16 + 8);
        send_byte(8'h12, 1'b1);
        idle(4);
        check("mrst_valid_rise", v_rise - b_v_rise, 1);
        check("mrst_data12",     32'(last_data),    32'h12);
        check("mrst_ferr_cnt",   fe_cyc - b_fe_cyc, 0);
        check("mrst_ovr_cnt",    ov_cyc - b_ov_cyc, 0);

`ifdef UART_RX_PARITY_EN
        // 0x07: even parity bit is 1; sending 0 must be rejected
        snap();
        par_flip = 1'b1;
        send_byte(8'h07, 1'b1);
        idle(4);
        check("par_bad_ferr",  fe_rise - b_fe_rise, 1);
        check("par_bad_valid", v_cyc - b_v_cyc,     0);
        par_flip = 1'b0;
        snap();
        send_byte(8'h07, 1'b1);
        idle(4);
        check("par_ok_valid", v_rise - b_v_rise, 1);
        check("par_ok_data",  32'(last_data),    32'h07);
        check("par_ok_ferr",  fe_cyc - b_fe_cyc, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Upstream stage of the adder-with-FIFO design. Converts serial rx into bytes and presents them on a valid/ready handshake to the FIFO write side.

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, line bit rate.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line; idle is high.
REQ-006 SHALL have port data, output, 8, received byte.
REQ-007 SHALL have port valid, output, 1, data holds an unconsumed byte.
REQ-008 SHALL have port ready, input, 1, consumer accepts data when valid&&ready.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse: a byte was dropped because the holding register was full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use; added latency is 2 clk.
REQ-012 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks (integer truncation, minimum 1); the divider is free-running only outside IDLE and restarts at 0 on start detect.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE->START SHALL occur on a synchronized rx high-to-low transition.
REQ-015 SHALL decide each bit by 2-of-3 majority of samples at ticks 7, 8 and 9 of the bit's 16 ticks.
REQ-016 In START, a majority of 1 SHALL be treated as a false start: return to IDLE with no output.
REQ-017 SHALL shift DATA LSB first, exactly 8 bits, using a 3-bit bit counter.
REQ-018 In STOP, a majority of 1 SHALL complete the byte; a majority of 0 SHALL pulse frame_err for 1 clk and discard the byte.
REQ-019 After the stop-bit decision (tick 9), the FSM SHALL return to IDLE so that the next start edge is detected within the same bit period.
REQ-020 A completed byte SHALL load data and set valid on the next clk edge when valid==0.
REQ-021 valid SHALL stay 1 and data stable until valid&&ready.
REQ-022 On valid&&ready with no byte completing that cycle, valid SHALL clear.
REQ-023 On valid&&ready in the same cycle a byte completes, data SHALL load the new byte and valid SHALL stay 1; overrun SHALL stay 0.
REQ-024 On a byte completing while valid&&!ready, the SHALL keep the old data, drop the new byte and pulse overrun for 1 clk.
REQ-025 ready while valid==0 SHALL have no effect.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously set FSM=IDLE, all counters=0, synchronizer flops=1, data=8'h00, valid=0, frame_err=0 and overrun=0.
REQ-027 A reset mid-frame SHALL abandon the frame; after release, the block SHALL ignore rx until the next high-to-low transition.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, the SHALL compile in the PARITY state, which samples one even-parity bit after DATA; a mismatch SHALL pulse frame_err and discard the byte.
REQ-029 Without UART_RX_PARITY_EN, the frame SHALL be 8N1 and no parity logic SHALL exist.

Verification (bench params: CLK_HZ=1_600_000, BAUD=100_000, giving DIV=1 and 16 clk/bit)
REQ-030 Send 8N1 byte 0xA5 with ready=1 -> valid pulses 1 clk with data=0xA5; frame_err=0 and overrun=0.
REQ-031 Send 0x3C then 0xC3 back-to-back with ready=0 -> data=0x3C with valid held; overrun pulses once; raise ready -> valid clears and data stays 0x3C.
REQ-032 Send 0x55 with the stop bit forced low -> frame_err pulses 1 clk; valid stays 0.
REQ-033 Drive rx low for 4 clk then high -> false start; no valid and no frame_err; a following 0x81 is received correctly.
REQ-034 Assert rst_n low at bit 4 of 0xFF, release, then send 0x12 -> outputs 0 during reset; only 0x12 is delivered.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity=0 (wrong) -> frame_err pulses; send it with parity=1 -> valid with data=0x07.
